// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   state_t     : sequencer states (IDLE, PREP, ITER, FIX, DONE)
//   OP_MULT/DIV : encoding of the op input
//   FUNCT_*     : R-type funct codes, also used by the control unit decoder
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1a;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
//   op       : OP_MULT = shift-add step, OP_DIV = restoring shift-subtract step
//   acc      : 2*DATA_W accumulator
//              MULT: {partial product high, remaining multiplier bits}
//              DIV : {partial remainder, dividend bits / quotient bits}
//   opnd     : multiplicand (MULT) or divisor (DIV), both non-negative
//   acc_next : accumulator after this step
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  op,
    input  logic [2*DATA_W-1:0]   acc,
    input  logic [DATA_W-1:0]     opnd,
    output logic [2*DATA_W-1:0]   acc_next
);

    // Multiply: add the multiplicand to the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole thing right.
    // The carry out of the add becomes the new top bit.
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Divide: shift the next dividend bit into the remainder, subtract the
    // divisor if it fits and shift the resulting quotient bit in at the bottom.
    // The remainder is always below the divisor, so the difference fits in DATA_W.
    logic [DATA_W:0]       rem_shift;
    logic [DATA_W-1:0]     rem_diff;
    logic                  rem_ge;
    logic [DATA_W-1:0]     rem_new;
    logic [2*DATA_W-1:0]   div_next;

    assign rem_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opnd});
    assign rem_diff  = rem_shift[DATA_W-1:0] - opnd;
    assign rem_new   = rem_ge ? rem_diff : rem_shift[DATA_W-1:0];
    assign div_next  = {rem_new, acc[DATA_W-2:0], rem_ge};

    assign acc_next = (op == OP_DIV) ? div_next : mul_next;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit with HI/LO registers.
// Sequence: IDLE -> PREP -> ITER (DATA_W cycles) -> FIX -> DONE -> IDLE.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : request, accepted only in IDLE (busy=0)
//   op             : OP_MULT / OP_DIV
//   op_a, op_b     : multiplicand/dividend and multiplier/divisor, sampled with start
//   uns            : unsigned operation (MULTU/DIVU), only when MULDIV_UNSIGNED_EN is defined
//   busy           : high from the accepting edge until the edge leaving DONE
//   done           : one-cycle completion pulse (in DONE)
//   div_zero       : high with done when a DIV had a zero divisor
//   hi, lo         : HI/LO result registers, updated only in FIX
// Handshake: start is a request that is sampled only while busy=0; a start
// seen while busy=1 is dropped. The result is valid in hi/lo when done=1
// and stays there until the next operation reaches FIX.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
    input  logic              uns,
`endif
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_q, op_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic                neg_res_q, neg_res_d;  // product / quotient negative
    logic                neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_zero_q, div_zero_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic uns_in;
`ifdef MULDIV_UNSIGNED_EN
    assign uns_in = uns;
`else
    assign uns_in = 1'b0;
`endif

    // Operand magnitudes; the most negative value maps to itself, which is
    // its correct unsigned magnitude.
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;
    assign a_neg = !uns_q && a_q[DATA_W-1];
    assign b_neg = !uns_q && b_q[DATA_W-1];
    assign a_abs = a_neg ? -a_q : a_q;
    assign b_abs = b_neg ? -b_q : b_q;

    logic [2*DATA_W-1:0] step_acc;
    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .op       (op_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc)
    );

    // Sign correction of the finished magnitudes.
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        uns_d      = uns_q;
        a_d        = a_q;
        b_d        = b_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        busy_d     = busy_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    uns_d   = uns_in;
                    a_d     = op_a;
                    b_d     = op_b;
                    busy_d  = 1'b1;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                if (op_q == OP_DIV && b_q == '0) begin
                    // No iterations and no HI/LO write on a zero divisor.
                    done_d     = 1'b1;
                    div_zero_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = {{DATA_W{1'b0}}, (op_q == OP_MULT) ? b_abs : a_abs};
                    opnd_d    = (op_q == OP_MULT) ? a_abs : b_abs;
                    cnt_d     = '0;
                    state_d   = ST_ITER;
                end
            end
            ST_ITER: begin
                acc_d = step_acc;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                if (op_q == OP_MULT) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d     = 1'b0;
                div_zero_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            uns_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            uns_q      <= uns_d;
            a_q        <= a_d;
            b_q        <= b_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases, start
// re-pulse and mid-operation reset, randomized signed (and, with
// MULDIV_UNSIGNED_EN, unsigned) operations against a 64-bit arithmetic model.
// Cycle indexing: the edge that accepts start is edge 0; the value seen at the
// falling edge just before rising edge n is reported as "at edge n".
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic         op       = 1'b0;
    logic         uns_drv  = 1'b0;
    logic [W-1:0] op_a     = '0;
    logic [W-1:0] op_b     = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // Reference HI/LO contents (retained across divide-by-zero).
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    muldiv_sequencer #(.DATA_W(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
`ifdef MULDIV_UNSIGNED_EN
        .uns      (uns_drv),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic u, output logic dz, output int lat);
        logic [63:0]        p;
        logic signed [63:0] q, r;
        dz  = 1'b0;
        lat = LAT;
        if (o == 1'b0) begin
            if (u) p = {32'b0, a} * {32'b0, b};
            else   p = longint'($signed(a)) * longint'($signed(b));
            mdl_hi = p[63:32];
            mdl_lo = p[31:0];
        end else if (b == '0) begin
            dz  = 1'b1;
            lat = 2;
        end else if (u) begin
            mdl_lo = a / b;
            mdl_hi = a % b;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            mdl_lo = q[31:0];
            mdl_hi = r[31:0];
        end
    endfunction

    // ---------------- driver ----------------
    // Issues one operation and monitors it until busy drops (bounded).
    // restart_at: edge at which start is pulsed again (0 = never).
    // reset_at  : edge before which rst_n is pulled low (0 = never); rst_n stays low on return.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                          input int restart_at, input int reset_at,
                          output int done_edge, output int busy_cycles,
                          output int done_cnt, output logic dz_seen);
        done_edge   = -1;
        busy_cycles = 0;
        done_cnt    = 0;
        dz_seen     = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        op_a    = a;
        op_b    = b;
        uns_drv = u;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 1'($urandom_range(0, 1));
        op_a    = $urandom;
        op_b    = $urandom;
        uns_drv = 1'($urandom_range(0, 1));
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == reset_at) begin
                rst_n = 1'b0;
                #1;
                break;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cnt++;
                done_edge = n;
                dz_seen   = div_zero;
            end
            if (!busy) break;
            if (n == restart_at) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
        checks++; if (hi !== '0)         begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== '0)         begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic         t_op [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] t_a  [5] = '{32'h7, 32'hFFFFFFF9, 32'h5, 32'h80000000, 32'h80000000};
        logic [W-1:0] t_b  [5] = '{32'hFFFFFFFD, 32'h2, 32'h0, 32'hFFFFFFFF, 32'h80000000};
        logic [W-1:0] t_hi [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h40000000};
        logic [W-1:0] t_lo [5] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h0};
        logic         t_dz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int           t_lat[5] = '{35, 35, 2, 35, 35};
        int de, bc, dc, lat;
        logic dz, mdz;
        for (int i = 0; i < 5; i++) begin
            model_op(t_op[i], t_a[i], t_b[i], 1'b0, mdz, lat);
            run_op(t_op[i], t_a[i], t_b[i], 1'b0, 0, 0, de, bc, dc, dz);
            checks++; if (hi !== t_hi[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, t_hi[i]); end
            checks++; if (lo !== t_lo[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, t_lo[i]); end
            checks++; if (dz !== t_dz[i]) begin errors++; $display("FAIL dir%0d_div_zero: got %b want %b", i, dz, t_dz[i]); end
            checks++; if (de !== t_lat[i]) begin errors++; $display("FAIL dir%0d_done_edge: got %0d want %0d", i, de, t_lat[i]); end
            checks++; if (bc !== t_lat[i]) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, t_lat[i]); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL dir%0d_done_count: got %0d want 1", i, dc); end
        end
    endtask

    task automatic test_restart_and_abort();
        int de, bc, dc, lat;
        logic dz, mdz;
        // start re-pulsed during iteration 5 is dropped
        model_op(1'b0, 32'd1000, 32'hFFFFFF00, 1'b0, mdz, lat);
        run_op(1'b0, 32'd1000, 32'hFFFFFF00, 1'b0, 7, 0, de, bc, dc, dz);
        checks++; if (dc !== 1)   begin errors++; $display("FAIL restart_done_count: got %0d want 1", dc); end
        checks++; if (bc !== LAT) begin errors++; $display("FAIL restart_busy_cycles: got %0d want %0d", bc, LAT); end
        checks++; if (lo !== mdl_lo || hi !== mdl_hi) begin
            errors++; $display("FAIL restart_result: got %h_%h want %h_%h", hi, lo, mdl_hi, mdl_lo);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_not_queued: got busy %b want 0", busy); end
        end
        // reset asserted during iteration 10 aborts immediately
        run_op(1'b1, 32'd99999, 32'd7, 1'b0, 0, 12, de, bc, dc, dz);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
        checks++; if (dc !== 0) begin errors++; $display("FAIL abort_done_count: got %0d want 0", dc); end
        mdl_hi = '0;
        mdl_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'd3, 32'd4, 1'b0, 0, 0, de, bc, dc, dz);
        checks++; if (lo !== 32'd12 || hi !== '0) begin errors++; $display("FAIL after_abort_result: got %h_%h want 0_c", hi, lo); end
        checks++; if (de !== LAT) begin errors++; $display("FAIL after_abort_latency: got %0d want %0d", de, LAT); end
        mdl_lo = 32'd12;
    endtask

    task automatic test_random();
        int de, bc, dc, lat;
        logic dz, mdz, o, u;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            o = 1'($urandom_range(0, 1));
            u = 1'b0;
`ifdef MULDIV_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`endif
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = W'($urandom_range(0, 300)) - 32'd150; b = W'($urandom_range(1, 20)); end
                3: b = W'($urandom_range(0, 40)) - 32'd20;
                default: ;
            endcase
            model_op(o, a, b, u, mdz, lat);
            run_op(o, a, b, u, 0, 0, de, bc, dc, dz);
            checks++; if (hi !== mdl_hi) begin errors++; $display("FAIL rnd%0d_hi: op %b uns %b a %h b %h got %h want %h", i, o, u, a, b, hi, mdl_hi); end
            checks++; if (lo !== mdl_lo) begin errors++; $display("FAIL rnd%0d_lo: op %b uns %b a %h b %h got %h want %h", i, o, u, a, b, lo, mdl_lo); end
            checks++; if (dz !== mdz) begin errors++; $display("FAIL rnd%0d_div_zero: got %b want %b", i, dz, mdz); end
            checks++; if (de !== lat) begin errors++; $display("FAIL rnd%0d_done_edge: got %0d want %0d", i, de, lat); end
            checks++; if (bc !== lat || dc !== 1) begin errors++; $display("FAIL rnd%0d_busy_done: got %0d/%0d want %0d/1", i, bc, dc, lat); end
        end
    endtask

`ifdef MULDIV_UNSIGNED_EN
    task automatic test_unsigned();
        int de, bc, dc, lat;
        logic dz, mdz;
        model_op(1'b0, 32'hFFFFFFFF, 32'h2, 1'b1, mdz, lat);
        run_op(1'b0, 32'hFFFFFFFF, 32'h2, 1'b1, 0, 0, de, bc, dc, dz);
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu: got %h_%h want 1_fffffffe", hi, lo); end
        model_op(1'b1, 32'hFFFFFFFF, 32'h10, 1'b1, mdz, lat);
        run_op(1'b1, 32'hFFFFFFFF, 32'h10, 1'b1, 0, 0, de, bc, dc, dz);
        checks++; if (hi !== 32'hF || lo !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu: got %h_%h want f_0fffffff", hi, lo); end
        model_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, mdz, lat);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 0, de, bc, dc, dz);
        checks++; if (hi !== 32'h80000000 || lo !== 32'h0) begin errors++; $display("FAIL divu_min: got %h_%h want 80000000_0", hi, lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_restart_and_abort();
        test_random();
`ifdef MULDIV_UNSIGNED_EN
        test_unsigned();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
